special_d_flip_flop_single: RTL and testbench
=============================================

// Module: special_d_flip_flop_single
//
// PURPOSE
// - Positive-edge D flip-flop with asynchronous, active-high reset.
// - On reset it loads a run-time-selectable value (ResetVal), not a fixed
//   constant.
// - It is the storage primitive of the two-mode timer. Counter and mode
//   registers are built from it, so each bit can power up to 0 or 1 as the
//   timer mode requires.
// - Single-bit by default; WIDTH allows a bank of identical, independent bits.
//
// PARAMETERS
// - WIDTH  1  number of independent flip-flop bits (must be >= 1)
//
// PORTS
// - clk       input   1      clock; rising edge is the active edge
// - rst       input   1      reset, asynchronous, active-high
// - ResetVal  input   WIDTH  value loaded into Q while reset applies
// - in        input   WIDTH  data input (D)
// - Q         output  WIDTH  registered output
// - Port order for positional instantiation: clk, rst, ResetVal, in, Q.
//
// BEHAVIOUR
// - Reset, rising edge of rst: Q <= ResetVal immediately (same time step).
//   No clk edge is needed.
// - Reset, rst held high: every rising clk edge reloads Q <= ResetVal.
//   in is ignored for the whole reset period.
// - Reset, ResetVal changes while rst is high with no clk edge: Q holds its
//   value until the next rising clk edge or the next rising edge of rst.
// - Reset output value: Q = ResetVal as sampled at the reset event.
//   There is no fixed constant reset value.
// - Normal operation, rst low: on each rising clk edge Q <= in.
//   Latency is 1 clk edge.
// - Q is stable between active edges. in and ResetVal may change freely
//   with no effect on Q.
// - Reset release: the falling edge of rst changes nothing. The first rising
//   clk edge after release captures in.
// - Simultaneous events: if rst is high at a clk edge, reset wins and
//   Q = ResetVal.
// - Width: all bits are independent. Bit i uses only ResetVal[i] and in[i].
// - Timing: there are no modelled delays. Q settles within the time step of
//   the triggering edge, so a check 0.1 ns later sees the new value.
// - Power-up: Q is X until the first reset or clk edge. Users must assert rst
//   at start-up.
// - Implementation: fully synthesizable. Use a single
//   always @(posedge clk or posedge rst) process per bit, or a
//   generate-for over WIDTH.
//
// TESTING
// - Start-up reset: assert rst with ResetVal=0 and in=0.
//   Required: Q=0 at the rst edge, before any clk edge.
// - ResetVal decoupling: set rst=0 and ResetVal=1 with in=0.
//   Required: at the next rising clk edge Q=0. ResetVal is ignored.
// - Follow input: in=0 for 1.5 cycles, then in=1 for 1 cycle, then in=0.
//   Required: Q is sampled at each rising edge (0, then 1, then 0).
//   Q never changes between edges.
// - Mid-operation reset: with Q=0 and ResetVal=1, raise rst between
//   clk edges.
//   Required: Q=1 immediately.
//   Required: Q stays 1 on the following clk edges while in=0.
// - Reset dominance: rst=1 at a clk edge where in differs from ResetVal.
//   Required: Q=ResetVal.
//   Then release rst. Required: the next rising edge gives Q=in.
// - WIDTH=4: ResetVal=4'b1010, pulse rst. Required: Q=4'b1010.
//   Then in=4'b0110 and one clk edge. Required: Q=4'b0110.
// - Bench self-check (every test): at each posedge clk or posedge rst, wait
//   0.1 ns, then check:
//   - rst=1 requires Q==ResetVal.
//   - otherwise Q==in.
//   Print a message on each mismatch.

Source files
------------

// File: rtl/special_d_flip_flop_single.sv
// Rising-edge D flip-flop bank with an asynchronous, active-high reset that
// loads a run-time-selectable value instead of a fixed constant.
`timescale 1ns/1ps

module special_d_flip_flop_single #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] ResetVal,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] Q
);

   // While rst is high every event reloads ResetVal, so ResetVal changes
   // without an edge leave Q untouched until the next clk or rst edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         Q <= ResetVal;
      end else begin
         Q <= in;
      end
   end

endmodule

// File: tb/tb_special_d_flip_flop_single.sv
// Randomized and directed bench for special_d_flip_flop_single, checked
// against an edge-event model on a 1-bit and a 4-bit instance.
`timescale 1ns/10ps

module tb_special_d_flip_flop_single;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [0:0] resetVal1 = 1'b0;
   logic [0:0] in1 = 1'b0;
   logic [0:0] q1;
   logic [3:0] resetVal4 = 4'b0000;
   logic [3:0] in4 = 4'b0000;
   logic [3:0] q4;

   int checkCount = 0;
   int passCount  = 0;

   logic [0:0] expQ1;
   logic [3:0] expQ4;
   bit         seenEvent = 1'b0;

   special_d_flip_flop_single #(.WIDTH(1)) dutSingle (
      .clk(clk), .rst(rst), .ResetVal(resetVal1), .in(in1), .Q(q1)
   );

   special_d_flip_flop_single #(.WIDTH(4)) dutWide (
      .clk(clk), .rst(rst), .ResetVal(resetVal4), .in(in4), .Q(q4)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [3:0] got,
                              input logic [3:0] want);
      checkCount++;
      if (got === want) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, got, want);
      end
   endtask

   task automatic applyStimulus(input logic rstV, input logic rv1V, input logic in1V,
                                input logic [3:0] rv4V, input logic [3:0] in4V);
      rst       = rstV;
      resetVal1 = rv1V;
      in1       = in1V;
      resetVal4 = rv4V;
      in4       = in4V;
   endtask

   task automatic toDrivePoint();
      @(negedge clk);
      #2;
   endtask

   task automatic toSamplePoint();
      @(posedge clk);
      #1;
   endtask

   // Model: every clk or rst rising edge captures ResetVal under reset, else in.
   always @(posedge clk or posedge rst) begin
      expQ1     = rst ? resetVal1 : in1;
      expQ4     = rst ? resetVal4 : in4;
      seenEvent = 1'b1;
      #0.1;
      checkOutput("edge q1", {3'b000, q1}, {3'b000, expQ1});
      checkOutput("edge q4", q4, expQ4);
   end

   // Between edges Q must still hold what the last event captured.
   always @(negedge clk) begin
      if (seenEvent) begin
         checkOutput("hold q1", {3'b000, q1}, {3'b000, expQ1});
         checkOutput("hold q4", q4, expQ4);
      end
   end

   initial begin
      // Start-up reset ahead of the first clk edge.
      #2;
      applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);
      #0.5;
      checkOutput("startup q1", {3'b000, q1}, 4'b0000);
      checkOutput("startup q4", q4, 4'b0000);

      // Release with ResetVal=1: the next edge must take in, not ResetVal.
      toDrivePoint();
      applyStimulus(1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000);
      toSamplePoint();
      checkOutput("decouple q1", {3'b000, q1}, 4'b0000);

      // Follow input 0 -> 1 -> 0.
      toDrivePoint();
      in1 = 1'b1;
      toSamplePoint();
      checkOutput("follow1 q1", {3'b000, q1}, 4'b0001);
      toDrivePoint();
      in1 = 1'b0;
      toSamplePoint();
      checkOutput("follow0 q1", {3'b000, q1}, 4'b0000);

      // Mid-operation reset between edges.
      toDrivePoint();
      rst = 1'b1;
      #0.5;
      checkOutput("midreset q1", {3'b000, q1}, 4'b0001);
      toSamplePoint();
      checkOutput("midreset hold q1", {3'b000, q1}, 4'b0001);

      // ResetVal change without an edge holds; next clk edge reloads it.
      toDrivePoint();
      in1       = 1'b1;
      resetVal1 = 1'b0;
      #0.5;
      checkOutput("rv change hold q1", {3'b000, q1}, 4'b0001);
      toSamplePoint();
      checkOutput("dominance q1", {3'b000, q1}, 4'b0000);
      toDrivePoint();
      rst = 1'b0;
      toSamplePoint();
      checkOutput("release q1", {3'b000, q1}, 4'b0001);

      // Wide bank reset and load.
      toDrivePoint();
      resetVal4 = 4'b1010;
      in4       = 4'b0101;
      rst       = 1'b1;
      #0.5;
      checkOutput("wide reset q4", q4, 4'b1010);
      toDrivePoint();
      rst = 1'b0;
      in4 = 4'b0110;
      toSamplePoint();
      checkOutput("wide load q4", q4, 4'b0110);

      // Randomized phase: random data, ResetVal and reset pulses.
      for (int i = 0; i < 400; i++) begin
         toDrivePoint();
         in1       = 1'($urandom);
         in4       = 4'($urandom);
         resetVal1 = 1'($urandom);
         resetVal4 = 4'($urandom);
         if (rst) begin
            if ($urandom_range(0, 2) == 0) rst = 1'b0;
         end else begin
            if ($urandom_range(0, 7) == 0) rst = 1'b1;
         end
         // Perturb inputs after the edge to prove Q ignores them until the next edge.
         @(posedge clk);
         #2;
         resetVal1 = 1'($urandom);
         resetVal4 = 4'($urandom);
         in1       = 1'($urandom);
         in4       = 4'($urandom);
      end

      toDrivePoint();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
